// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states and bus-level constants, also used by i2c_master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W    = 7;
  localparam int unsigned I2C_BYTE_W    = 8;
  localparam int unsigned I2C_BIT_CNT_W = 4;

  localparam logic                  I2C_ACK          = 1'b0;
  localparam logic                  I2C_NACK         = 1'b1;
  localparam logic                  I2C_RW_WRITE     = 1'b0;
  localparam logic                  I2C_RW_READ      = 1'b1;
  localparam logic [I2C_ADDR_W-1:0] I2C_GENERAL_CALL = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } slave_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with registered edge strobes and START/STOP detection.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];

  // Flops reset to the idle-bus level so leaving reset never fakes a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q     <= '1;
      sda_q     <= '1;
      scl_h     <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      scl_q     <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q     <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_h     <= scl_s;
      sda_h     <= sda_s;
      scl_rise  <= scl_s & ~scl_h;
      scl_fall  <= ~scl_s & scl_h;
      start_det <= scl_s & scl_h & sda_h & ~sda_s;
      stop_det  <= scl_s & scl_h & ~sda_h & sda_s;
      sda_bit   <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, ACK, byte receive and transmit on an open-drain bus.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept writes to the general-call address.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_req,
  output logic                  rw,
  output logic                  busy
);

  logic                     sda_oe;
  logic                     scl_rise;
  logic                     scl_fall;
  logic                     start_det;
  logic                     stop_det;
  logic                     sda_bit;
  slave_state_t             state;
  logic [I2C_BYTE_W-1:0]    shreg;
  logic [I2C_BIT_CNT_W-1:0] bit_cnt;
  logic                     ack_phase;
  logic [I2C_BYTE_W-1:0]    shift_in_c;
  logic                     addr_hit_c;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_bit  (sda_bit)
  );

  // Byte as it will look after the current bit is shifted in, and its address decode.
  always_comb begin
    shift_in_c = {shreg[I2C_BYTE_W-2:0], sda_bit};
    addr_hit_c = (shift_in_c[I2C_BYTE_W-1:1] == SLAVE_ADDR);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    if ((shift_in_c[I2C_BYTE_W-1:1] == I2C_GENERAL_CALL) && (shift_in_c[0] == I2C_RW_WRITE)) begin
      addr_hit_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg <= shift_in_c;
              if (bit_cnt == I2C_BIT_CNT_W'(7)) begin
                bit_cnt <= '0;
                if (addr_hit_c) begin
                  rw        <= shift_in_c[0];
                  busy      <= 1'b1;
                  ack_phase <= 1'b0;
                  state     <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + I2C_BIT_CNT_W'(1);
              end
            end
          end
          // First fall drives the ACK; second fall ends it and starts the data phase.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else if (rw == I2C_RW_WRITE) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end else begin
                shreg   <= tx_data;
                tx_req  <= 1'b1;
                sda_oe  <= ~tx_data[I2C_BYTE_W-1];
                bit_cnt <= I2C_BIT_CNT_W'(1);
                state   <= RD_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg <= shift_in_c;
              if (bit_cnt == I2C_BIT_CNT_W'(7)) begin
                bit_cnt   <= '0;
                rx_data   <= shift_in_c;
                rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                state     <= WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + I2C_BIT_CNT_W'(1);
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end
          end
          // bit_cnt counts bits already placed on the bus; the 8th fall hands SDA to the master.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == I2C_BIT_CNT_W'(8)) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                shreg   <= {shreg[I2C_BYTE_W-2:0], 1'b0};
                sda_oe  <= ~shreg[I2C_BYTE_W-2];
                bit_cnt <= bit_cnt + I2C_BIT_CNT_W'(1);
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_bit == I2C_NACK) begin
                state <= WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              shreg   <= tx_data;
              tx_req  <= 1'b1;
              sda_oe  <= ~tx_data[I2C_BYTE_W-1];
              bit_cnt <= I2C_BIT_CNT_W'(1);
              state   <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Scoreboard bench for i2c_slave: a bus-master model drives SCL/SDA, a monitor checks DUT outputs.
module tb_i2c_slave;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       rw;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int drove_cnt = 0;
  int busy_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  always_comb tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;

  i2c_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_req  (tx_req),
    .rw      (rw),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid and advances tx data on tx_req.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
    if (tx_req) begin
      tx_cnt++;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
    end
    if (!m_low && sda === 1'b0) drove_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_bit(input logic drive_one, output logic sampled);
    wait_q(); m_low = ~drive_one;
    wait_q(); scl = 1'b1;
    wait_q(); sampled = sda;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); m_low = 1'b1;
    wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); m_low = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); m_low = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_bit);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack_bit);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
    bus_bit(nack, s);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         rx_before;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sda", 32'(sda), 32'h1);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_req", 32'(tx_req), 32'h0);
    check("rst_rw", 32'(rw), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Write 0xA5 to 0x42
    bus_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", 32'(ack), 32'h0);
    check("wr_busy", 32'(busy), 32'h1);
    check("wr_rw", 32'(rw), 32'h0);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, ack);
    check("wr_data_ack", 32'(ack), 32'h0);
    bus_stop();
    check("wr_busy_after_stop", 32'(busy), 32'h0);

    // Address 0x17 must be ignored entirely
    drove_cnt = 0; busy_cnt = 0; rx_before = rx_cnt;
    bus_start();
    write_byte(8'h2E, ack);
    check("miss_addr_nack", 32'(ack), 32'h1);
    write_byte(8'hFF, ack);
    check("miss_data_nack", 32'(ack), 32'h1);
    bus_stop();
    check("miss_sda_driven", 32'(drove_cnt), 32'h0);
    check("miss_busy_cycles", 32'(busy_cnt), 32'h0);
    check("miss_rx_count", 32'(rx_cnt - rx_before), 32'h0);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
    tx_cnt = 0;
    bus_start();
    write_byte(8'h85, ack);
    check("rd_addr_ack", 32'(ack), 32'h0);
    check("rd_rw", 32'(rw), 32'h1);
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'h3C);
    read_byte(1'b1, d);
    check("rd_byte1", 32'(d), 32'hC3);
    drove_cnt = 0;
    repeat (20) @(negedge clk);
    check("rd_released_after_nack", 32'(drove_cnt), 32'h0);
    bus_stop();
    check("rd_tx_req_count", 32'(tx_cnt), 32'h2);

    // Write 0x11, repeated START, read 0x99
    tx_q.push_back(8'h99);
    exp_rx.push_back(8'h11);
    bus_start();
    write_byte(8'h84, ack);
    check("sr_wr_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h11, ack);
    check("sr_wr_data_ack", 32'(ack), 32'h0);
    bus_start();
    write_byte(8'h85, ack);
    check("sr_rd_addr_ack", 32'(ack), 32'h0);
    check("sr_rw", 32'(rw), 32'h1);
    read_byte(1'b1, d);
    check("sr_rd_byte", 32'(d), 32'h99);
    bus_stop();
    check("sr_rx_data_kept", 32'(rx_data), 32'h11);

    // Partial byte cut by STOP, then a full write of 0x5A
    rx_before = rx_cnt;
    bus_start();
    write_byte(8'h84, ack);
    check("part_addr_ack", 32'(ack), 32'h0);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b0, s);
    bus_stop();
    check("part_no_rx", 32'(rx_cnt - rx_before), 32'h0);
    exp_rx.push_back(8'h5A);
    bus_start();
    write_byte(8'h84, ack);
    write_byte(8'h5A, ack);
    check("part_next_ack", 32'(ack), 32'h0);
    bus_stop();
    check("part_rx_data", 32'(rx_data), 32'h5A);

    // General-call address
    bus_start();
    write_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    check("gc_addr_ack", 32'(ack), 32'h0);
`else
    check("gc_addr_ack", 32'(ack), 32'h1);
`endif
    bus_stop();

    // Reset in the middle of a read byte of 0x00
    bus_start();
    write_byte(8'h85, ack);
    check("rstmid_addr_ack", 32'(ack), 32'h0);
    bus_bit(1'b1, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
    check("rstmid_bit2", 32'(s), 32'h0);
    repeat (Q) @(negedge clk);
    check("rstmid_driving", 32'(sda), 32'h0);
    rst = 1'b1;
    #1;
    check("rstmid_sda_released", 32'(sda), 32'h1);
    check("rstmid_rx_data", 32'(rx_data), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_rw", 32'(rw), 32'h0);
    check("rstmid_tx_req", 32'(tx_req), 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    bus_stop();
    exp_rx.push_back(8'h77);
    bus_start();
    write_byte(8'h84, ack);
    check("post_rst_addr_ack", 32'(ack), 32'h0);
    write_byte(8'h77, ack);
    check("post_rst_data_ack", 32'(ack), 32'h0);
    bus_stop();
    check("post_rst_busy", 32'(busy), 32'h0);

    repeat (10) @(negedge clk);
    check("rx_pending", 32'(exp_rx.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
